imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 256, instruction memory depth in 32-bit words.
REQ-002 Parameter: ADDR_W, 8, word-address width (log2 DEPTH).
REQ-003 Port: clk  input  1  sole clock, rising-edge active.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  one-cycle request to begin a load.
REQ-006 Port: abort  input  1  cancels an active load.
REQ-007 Port: load_len  input  ADDR_W+1  number of words to load, sampled on an accepted start.
REQ-008 Port: byte_in  input  8  serial program byte.
REQ-009 Port: byte_valid  input  1  byte_in is valid.
REQ-010 Port: byte_ready  output  1  loader accepts byte_in this cycle.
REQ-011 Port: wr_en  output  1  instruction-memory word write strobe.
REQ-012 Port: wr_addr  output  ADDR_W  word address of the write.
REQ-013 Port: wr_data  output  32  word to write.
REQ-014 Port: cpu_hold  output  1  holds the pipeline (PC and fetch) while memory contents are invalid.
REQ-015 Port: busy  output  1  a load is in progress.
REQ-016 Port: done  output  1  one-cycle pulse when a load completes.
REQ-017 Port: err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-018 The state machine SHALL have the states IDLE, RECV, WRITE and DONE.
REQ-019 In IDLE, start with 1 <= load_len <= DEPTH SHALL latch load_len, clear the byte and word counters, set cpu_hold, and move to RECV.
REQ-020 In IDLE, start with load_len==0 or load_len>DEPTH SHALL pulse err for one cycle, stay in IDLE, and leave cpu_hold unchanged.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 byte_ready SHALL be 1 only in RECV while abort==0.
REQ-023 A handshake (byte_valid & byte_ready) SHALL place the byte little-endian: byte k (k=0..3) goes to wr_data[8k+7:8k].
REQ-024 The 2-bit byte counter SHALL increment on each handshake and wrap from 3 to 0.
REQ-025 The 4th handshake SHALL move the block to WRITE.
REQ-026 In WRITE, the block SHALL assert wr_en for exactly one cycle, which is the cycle after the 4th handshake, with wr_addr = current word count.
REQ-027 After WRITE, the block SHALL go to DONE if word count + 1 == latched length; otherwise it SHALL increment the word count and return to RECV.
REQ-028 DONE SHALL last one cycle: pulse done, clear cpu_hold, then return to IDLE.
REQ-029 busy SHALL be 1 in RECV and WRITE only.
REQ-030 wr_data SHALL hold its value when wr_en==0.
REQ-031 abort in RECV or WRITE SHALL return the block to IDLE next cycle, suppress wr_en in that cycle, keep cpu_hold=1, and emit no done.
REQ-032 If abort and a 4th byte coincide, abort SHALL win and the byte SHALL not be accepted (byte_ready==0).
REQ-033 abort in IDLE or DONE SHALL have no effect.
REQ-034 A load of DEPTH words SHALL write addresses 0..DEPTH-1 without wrap; the word counter SHALL never exceed DEPTH-1.
REQ-035 byte_valid gaps SHALL stall reception indefinitely, with no timeout.

Reset
REQ-036 rst SHALL force, asynchronously, state=IDLE, counters=0, wr_data=0, wr_en=0, byte_ready=0, busy=0, done=0, err=0 and cpu_hold=1.
REQ-037 rst asserted mid-load SHALL discard the partial word; words already written are not restored.

Structure
REQ-038 The state encoding and the DEPTH/ADDR_W defaults SHALL reside in a shared package also used by the instruction memory.
REQ-039 One sub-module, byte_packer (byte counter plus 32-bit little-endian assembly register), SHALL be used; the FSM stays in imem_loader.

Verification
REQ-040 Reset release, start with load_len=1, bytes 0x13,0x00,0x00,0x20 -> one wr_en at addr 0 with wr_data=0x20000013, then done pulse, then cpu_hold=0.
REQ-041 load_len=3, 12 bytes with random byte_valid gaps -> wr_en at addrs 0,1,2 in order, each one cycle after its 4th byte; done follows addr 2.
REQ-042 start with load_len=0, and separately with 257 -> err pulse, no state change, byte_ready stays 0.
REQ-043 abort coinciding with the 8th byte of a 4-word load -> byte not accepted, no write to addr 1, IDLE next cycle, cpu_hold=1, no done.
REQ-044 load_len=256 full load -> last write at addr 255, done; a start pulsed mid-load is ignored.
REQ-045 rst asserted between the 2nd and 3rd bytes -> all outputs reach reset values immediately; a following 1-word load writes only the new bytes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction
// memory itself: default geometry and the loader state encoding.
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_ADDR_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: load control, serial byte stream, memory write port and status.
// master = host/stream/memory side, slave = the loader.
interface imem_loader_if #(
  parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W
);
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   load_len;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, abort, load_len, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, abort, load_len, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Byte counter plus little-endian word assembly. Bytes 0..2 are stored;
// the 4th byte is merged combinationally so the full word is available in
// the same cycle as the 4th handshake.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;

  assign last_o = (cnt_q == 2'd3);
  assign word_o = {byte_i, asm_q};

  // Next-state: clear on a new load, otherwise store byte k in lane k and
  // advance the counter (wraps 3 -> 0).
  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clr_i) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (shift_i) begin
      cnt_d = cnt_q + 2'd1;
      if (!last_o) asm_d[{cnt_q, 3'b000} +: 8] = byte_i;
    end
  end

  // Counter and assembly register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: accepts a byte stream, packs it into
// 32-bit little-endian words, writes them to consecutive word addresses and
// holds the CPU until a full load has completed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              err_q, err_d;

  logic        byte_ready, hs, len_ok, word_last;
  logic        pk_clr, pk_last;
  logic [31:0] pk_word;

  assign byte_ready = (state_q == ST_RECV) && !bus.abort;
  assign hs         = bus.byte_valid && byte_ready;
  assign len_ok     = (bus.load_len != '0) && (bus.load_len <= LEN_MAX);
  assign word_last  = (({1'b0, word_q} + (ADDR_W+1)'(1)) == len_q);

  byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pk_clr),
    .shift_i (hs),
    .byte_i  (bus.byte_in),
    .last_o  (pk_last),
    .word_o  (pk_word)
  );

  // Load FSM: IDLE -> RECV (4 bytes) -> WRITE -> RECV ... -> DONE -> IDLE.
  // abort wins over everything in RECV/WRITE and leaves cpu_hold asserted.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    err_d      = 1'b0;
    pk_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            len_d      = bus.load_len;
            word_d     = '0;
            pk_clr     = 1'b1;
            cpu_hold_d = 1'b1;
            state_d    = ST_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (hs && pk_last) begin
          wr_data_d = pk_word;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (word_last) begin
          state_d = ST_DONE;
        end else begin
          word_d  = word_q + 1'b1;
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        cpu_hold_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader state; reset holds the CPU since memory contents are unknown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_q     <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      err_q      <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = (state_q == ST_WRITE) && !bus.abort;
  assign bus.wr_addr    = word_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and popped when the loader strobes wr_en.
module tb_imem_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_wr_cyc = -100;
  wr_t  sb[$];

  imem_loader_if #(.ADDR_W(8)) bus();

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: pop/compare writes, check write latency and done timing.
  initial begin
    logic [1:0] bcnt;
    logic       fourth_prev;
    logic       hs;
    wr_t        e;
    bcnt = '0;
    fourth_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wr_en) begin
        if (sb.size() == 0) begin
          chk("unexp_wr", bus.wr_addr, 64'hffff);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", bus.wr_addr, e.addr);
          chk("wr_data", bus.wr_data, e.data);
          chk("wr_lat", fourth_prev, 1);
        end
        last_wr_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_after_wr", cyc - last_wr_cyc, 1);
      end
      hs = bus.byte_valid && bus.byte_ready;
      fourth_prev = hs && (bcnt == 2'd3);
      if (rst || (bus.start && !bus.busy)) bcnt = '0;
      else if (hs) bcnt = bcnt + 2'd1;
    end
  end

  // All driving tasks start and end #1 after a rising edge.
  task automatic start_load(input logic [8:0] len);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.load_len = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    bus.byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b1;
    bus.byte_in = b;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = bus.byte_ready;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
    if (!acc) chk("hs_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input int gapmax);
    sb.push_back('{addr: addr, data: w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, gapmax));
  endtask

  task automatic wait_done(input int max);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = bus.done;
    end
    chk("done_seen", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.start = 0; bus.abort = 0; bus.load_len = '0;
    bus.byte_in = '0; bus.byte_valid = 0;

    // Reset state
    #7;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_hold", bus.cpu_hold, 1);
    chk("rst_data", bus.wr_data, 0);
    @(posedge clk); #1; rst = 0;

    // Single-word load
    start_load(9'd1);
    chk("l1_busy", bus.busy, 1);
    chk("l1_ready", bus.byte_ready, 1);
    chk("l1_hold", bus.cpu_hold, 1);
    sb.push_back('{addr: 8'd0, data: 32'h2000_0013});
    send_byte(8'h13, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h20, 0);
    wait_done(10);
    @(negedge clk);
    chk("l1_hold_clr", bus.cpu_hold, 0);
    chk("l1_idle", bus.busy, 0);
    chk("l1_data_held", bus.wr_data, 32'h2000_0013);
    chk("l1_sb_empty", sb.size(), 0);

    // 3-word load with random byte_valid gaps
    start_load(9'd3);
    for (int w = 0; w < 3; w++) send_word(w[7:0], $urandom, 3);
    wait_done(20);
    chk("l3_sb_empty", sb.size(), 0);

    // Rejected lengths: 0 and DEPTH+1
    start_load(9'd0);
    chk("len0_err", bus.err, 1);
    chk("len0_busy", bus.busy, 0);
    chk("len0_ready", bus.byte_ready, 0);
    chk("len0_hold", bus.cpu_hold, 0);
    @(posedge clk); #1;
    chk("len0_err_pulse", bus.err, 0);
    start_load(9'd257);
    chk("len257_err", bus.err, 1);
    chk("len257_ready", bus.byte_ready, 0);
    chk("len257_hold", bus.cpu_hold, 0);
    @(posedge clk); #1;
    chk("len257_err_pulse", bus.err, 0);
    chk("len257_busy", bus.busy, 0);

    // Abort on the 8th byte of a 4-word load
    d0 = done_cnt;
    start_load(9'd4);
    send_word(8'd0, 32'hcafe_f00d, 1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    bus.byte_valid = 1'b1; bus.byte_in = 8'h44; bus.abort = 1'b1;
    #1;
    chk("abort_ready", bus.byte_ready, 0);
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.byte_valid = 1'b0;
    chk("abort_idle", bus.busy, 0);
    chk("abort_hold", bus.cpu_hold, 1);
    chk("abort_wr_en", bus.wr_en, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, d0);
    chk("abort_sb_empty", sb.size(), 0);

    // Full DEPTH load with an ignored mid-load start
    start_load(9'd256);
    for (int w = 0; w < 256; w++) begin
      if (w == 100) begin
        bus.start = 1'b1; bus.load_len = 9'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("mid_start_busy", bus.busy, 1);
        chk("mid_start_err", bus.err, 0);
      end
      send_word(w[7:0], $urandom, 0);
    end
    wait_done(10);
    chk("full_sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("full_hold_clr", bus.cpu_hold, 0);

    // Reset between the 2nd and 3rd byte
    start_load(9'd1);
    send_byte(8'haa, 0); send_byte(8'hbb, 0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_ready", bus.byte_ready, 0);
    chk("mrst_hold", bus.cpu_hold, 1);
    chk("mrst_data", bus.wr_data, 0);
    chk("mrst_wr_en", bus.wr_en, 0);
    chk("mrst_done", bus.done, 0);
    @(posedge clk); #1; rst = 1'b0;
    start_load(9'd1);
    send_word(8'd0, 32'h0403_0201, 2);
    wait_done(10);
    chk("mrst_sb_empty", sb.size(), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
